uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serial UART transmitter: accepts a parallel byte on a single-cycle valid strobe and sends it as one frame on `TX_OUT`. The frame is start bit, 8 data bits LSB-first, an optional parity bit, and one stop bit. It is the line-side source for the UART receive path: `TX_OUT` drives the receiver's `RX_IN` in loopback. It uses the same `prescale`, `parity_enable` and `parity_type` conventions as the receiver, so both ends configured identically interoperate.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data bits per frame. Only 8 is supported.

Ports:
- `clk`  input  1  system clock, single clock domain.
- `rst`  input  1  reset; synchronous and active-high.
- `P_DATA`  input  8  byte to transmit.
- `data_valid`  input  1  one-cycle strobe qualifying `P_DATA`.
- `prescale`  input  6  `clk` cycles per bit period; 0 is treated as 64.
- `parity_enable`  input  1  1 = insert parity bit.
- `parity_type`  input  1  0 = even, 1 = odd.
- `TX_OUT`  output  1  serial line, registered; idle level 1.
- `busy`  output  1  frame in progress, registered.
- `ready`  output  1  a `data_valid` in this cycle will be accepted (combinational from state).

## Operation
States:
- IDLE → START on an accepted strobe.
- START → DATA after one bit period.
- DATA → PARITY after bit 7 when the captured parity enable is 1; DATA → STOP when it is 0.
- PARITY → STOP after one bit period.
- STOP → IDLE, or → START when a held byte is pending (see Configuration).

Accept:
- A strobe is accepted when `data_valid && ready`.
- Accept captures `P_DATA`, `parity_enable`, `parity_type` and `prescale` into frame registers.
- Input changes mid-frame have no effect.

Bit timing:
- Bit counter 0–7 and period counter 0..P-1, where P = `prescale`, or 64 when `prescale` is 0.
- A bit ends when the period counter reaches P-1. The period counter then wraps to 0.

Line levels:
- START drives 0; STOP drives 1.
- DATA drives `data[bit_count]`, LSB first.
- PARITY drives the parity bit:
  - even (`parity_type` = 0): `^data`;
  - odd (`parity_type` = 1): `~^data`.

Other rules:
- `ready` = (state == IDLE), unless the holding buffer is compiled in.
- With `ready` low, `data_valid` is ignored and the byte is dropped. No error flag is raised.

Reset:
- `rst` high at any clock edge forces IDLE, `TX_OUT`=1, `busy`=0, counters=0, holding buffer empty.
- A frame in progress is abandoned immediately; the line returns to 1 on the next cycle.
- `rst` has priority over a simultaneous `data_valid`.

## Timing
- Strobe accepted at edge N: `TX_OUT` falls and `busy` rises at edge N+1.
- Each bit lasts exactly P cycles.
- Frame length is 10·P cycles without parity, 11·P with parity.
- `busy` falls on the edge after the last STOP cycle, which is the edge `TX_OUT` would start a new bit.
- In IDLE the line stays at 1 indefinitely.
- Minimum inter-frame gap without the holding buffer:
  - a strobe may be accepted in the first cycle `ready` is high (the cycle after `busy` falls);
  - the next START therefore follows the STOP bit with a gap of exactly 1 cycle at idle level.
- P = 1 is legal; each bit is then 1 cycle.

## Configuration
- Macro `UART_TX_HOLD_EN`: compiles in a one-entry holding buffer, which stores byte, parity enable, parity type and prescale.
- With the macro:
  - `ready` = IDLE or holding buffer empty.
  - A strobe accepted while `busy` is high fills the buffer.
  - At the end of STOP with the buffer full, the FSM goes directly to START (zero idle cycles) and the buffer empties on that same edge.
  - A strobe coinciding with the STOP→START drain edge is accepted into the now-empty buffer.
  - A strobe in IDLE bypasses the buffer.
  - `busy` stays high across back-to-back frames.
- Without the macro: no buffer exists; behaviour is exactly the ready/drop rule in Operation.

## Test plan
- Reset, then idle 100 cycles: `TX_OUT`=1, `busy`=0, `ready`=1 throughout.
- `prescale`=8, parity off, `P_DATA`=0xA5 strobed at cycle 0: from cycle 1, line is 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; `busy` high for 80 cycles.
- `prescale`=16, parity on, even: 0x07 → parity bit 1; odd: 0x07 → parity bit 0. Frame is 176 cycles. Loopback into the receiver gives `P_DATA`=0x07, `parity_error`=0, `stop_error`=0.
- Strobe 0x3C, then strobe 0xFF at cycle 20 while `busy`: without macro 0xFF is dropped and only one frame is sent; with `UART_TX_HOLD_EN` 0xFF's START immediately follows 0x3C's STOP and `busy` never drops between them.
- `rst` asserted mid-frame during data bit 3: next cycle `TX_OUT`=1, `busy`=0. A new strobe of 0x81 then produces a clean full frame.
- `prescale`=0 → 64-cycle bits; `prescale`=1 → 10-cycle frame for 0x00 (line 0 for 9 cycles, then 1).

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame - serial UART transmitter.
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, one stop
// bit (1). Each bit lasts `prescale` clocks, with 0 meaning 64 clocks.
// Configuration macro: UART_TX_HOLD_EN adds a one-entry holding buffer so
// that a byte offered mid-frame is queued and sent back-to-back. Without the
// macro, a byte offered while a frame is in progress is dropped.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic [5:0]            prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  ready
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Control state
    state_t state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [5:0] cnt_q, cnt_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    // Frame registers: captured when a byte is launched, static for the frame
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic [5:0]            last_q, last_d;

    logic bit_end;
    logic accept;

`ifdef UART_TX_HOLD_EN
    // Holding buffer: one queued byte with its own line settings
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_par_en_q, hold_par_en_d;
    logic                  hold_par_type_q, hold_par_type_d;
    logic [5:0]            hold_last_q, hold_last_d;
    logic                  stop_end;
`endif

    // Last period-counter value of a bit: P-1, where a prescale of 0 means P=64
    function automatic logic [5:0] period_last(input logic [5:0] presc);
        if (presc == 6'd0) begin
            return 6'd63;
        end
        return presc - 6'd1;
    endfunction

    // Parity bit: even parity is the XOR of the data, odd parity its inverse
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                        input logic                  odd);
        return odd ? ~(^d) : ^d;
    endfunction

    // Bit-period boundary and the accept decision seen by the producer
    always_comb begin
        bit_end = (cnt_q == last_q);
`ifdef UART_TX_HOLD_EN
        stop_end = (state_q == S_STOP) && bit_end;
        // A full buffer drains on the last STOP cycle, so a strobe in that
        // same cycle can take its place.
        ready    = (state_q == S_IDLE) || !hold_full_q || stop_end;
`else
        ready    = (state_q == S_IDLE);
`endif
        accept   = data_valid && ready;
    end

    // Next-state, counters, frame capture and registered line level
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        last_d     = last_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
`ifdef UART_TX_HOLD_EN
        hold_full_d     = hold_full_q;
        hold_data_d     = hold_data_q;
        hold_par_en_d   = hold_par_en_q;
        hold_par_type_d = hold_par_type_q;
        hold_last_d     = hold_last_q;
`endif

        // The period counter runs in every active state and wraps at P-1
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START;
                    bit_d      = 3'd0;
                    cnt_d      = 6'd0;
                    data_d     = P_DATA;
                    par_en_d   = parity_enable;
                    par_type_d = parity_type;
                    last_d     = period_last(prescale);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_d = 3'd0;
`ifdef UART_TX_HOLD_EN
                    if (hold_full_q) begin
                        // Queued byte goes straight out with no idle cycle
                        state_d     = S_START;
                        data_d      = hold_data_q;
                        par_en_d    = hold_par_en_q;
                        par_type_d  = hold_par_type_q;
                        last_d      = hold_last_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Empty buffer and a strobe right at the end of STOP:
                        // launch it directly rather than parking it.
                        state_d    = S_START;
                        data_d     = P_DATA;
                        par_en_d   = parity_enable;
                        par_type_d = parity_type;
                        last_d     = period_last(prescale);
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                bit_d   = 3'd0;
                cnt_d   = 6'd0;
            end
        endcase

`ifdef UART_TX_HOLD_EN
        // A strobe taken mid-frame is parked, except the one launched above
        if (accept && (state_q != S_IDLE) && !(stop_end && !hold_full_q)) begin
            hold_full_d     = 1'b1;
            hold_data_d     = P_DATA;
            hold_par_en_d   = parity_enable;
            hold_par_type_d = parity_type;
            hold_last_d     = period_last(prescale);
        end
`endif

        // Line level and busy follow the state being entered, so both
        // outputs change on the same edge as the state register.
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = parity_bit(data_d, par_type_d);
            default:  tx_d = 1'b1;
        endcase
    end

    // Control registers with synchronous reset; reset abandons any frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= 3'd0;
            cnt_q   <= 6'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_HOLD_EN
            hold_full_q <= hold_full_d;
`endif
        end
    end

    // Frame and buffer payload; only read while the matching control is live
    always_ff @(posedge clk) begin
        data_q     <= data_d;
        par_en_q   <= par_en_d;
        par_type_q <= par_type_d;
        last_q     <= last_d;
`ifdef UART_TX_HOLD_EN
        hold_data_q     <= hold_data_d;
        hold_par_en_q   <= hold_par_en_d;
        hold_par_type_q <= hold_par_type_d;
        hold_last_q     <= hold_last_d;
`endif
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame - self-checking bench for uart_tx_frame.
// A line monitor decodes TX_OUT cycle by cycle against a scoreboard of
// expected frames; directed sequences cover timing, drop/hold, gap and reset.
module tb_uart_tx_frame;

`ifdef UART_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic       TX_OUT;
    logic       busy;
    logic       ready;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .prescale      (prescale),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .TX_OUT        (TX_OUT),
        .busy          (busy),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected frames
    typedef struct {
        logic [7:0] data;
        int         p;
        bit         pen;
        bit         par;
        bit         gap0;   // must start on the cycle right after the previous STOP
    } exp_t;

    exp_t sb_q[$];

    task automatic push(input logic [7:0] d, input logic [5:0] ps, input bit pen,
                        input bit par, input bit gap0);
        exp_t e;
        e.data = d;
        e.p    = (ps == 6'd0) ? 64 : int'(ps);
        e.pen  = pen;
        e.par  = par;
        e.gap0 = gap0;
        sb_q.push_back(e);
    endtask

    function automatic bit exp_level(input exp_t e, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[3'(b - 1)];
        if (e.pen && b == 9) return e.par;
        return 1'b1;
    endfunction

    // Line monitor
    bit   mon_abort = 1'b1;
    bit   in_frame  = 1'b0;
    bit   post      = 1'b0;
    int   bidx, cidx;
    exp_t cur;

    always @(negedge clk) begin
        if (mon_abort) begin
            in_frame = 1'b0;
            post     = 1'b0;
        end else begin
            if (!in_frame && post) begin
                post = 1'b0;
                if (sb_q.size() > 0 && sb_q[0].gap0) begin
                    cur = sb_q.pop_front();
                    in_frame = 1'b1;
                    bidx = 0;
                    cidx = 0;
                end else begin
                    chk("busy_after_stop", busy, 1'b0);
                    chk("line_after_stop", TX_OUT, 1'b1);
                end
            end else if (!in_frame && TX_OUT == 1'b0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame_start", TX_OUT, 1'b1);
                end else begin
                    cur = sb_q.pop_front();
                    in_frame = 1'b1;
                    bidx = 0;
                    cidx = 0;
                end
            end
            if (in_frame) begin
                chk($sformatf("line_bit%0d_byte%02h", bidx, cur.data), TX_OUT, exp_level(cur, bidx));
                chk("busy_in_frame", busy, 1'b1);
                cidx++;
                if (cidx == cur.p) begin
                    cidx = 0;
                    bidx++;
                    if (bidx == (cur.pen ? 11 : 10)) begin
                        in_frame = 1'b0;
                        post     = 1'b1;
                    end
                end
            end
        end
    end

    // Drive a strobe's inputs (caller clears data_valid after one edge)
    task automatic drive(input logic [7:0] d, input logic [5:0] ps, input bit pen, input bit pt);
        P_DATA        = d;
        prescale      = ps;
        parity_enable = pen;
        parity_type   = pt;
        data_valid    = 1'b1;
    endtask

    // From a falling clock edge, wait for busy low; inputs are scrambled
    // meanwhile to show a running frame ignores them.
    task automatic wait_low(output int t1);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            P_DATA        = 8'($urandom_range(0, 255));
            prescale      = 6'($urandom_range(0, 63));
            parity_enable = 1'($urandom_range(0, 1));
            parity_type   = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("busy_fall_in_time", busy, 1'b0);
        t1 = cyc;
    endtask

    // Send one frame and check launch latency and busy duration
    task automatic run_frame(input logic [7:0] d, input logic [5:0] ps, input bit pen,
                             input bit pt, input bit par, input int len);
        int t0, t1;
        @(posedge clk);
        #1;
        drive(d, ps, pen, pt);
        push(d, ps, pen, par, 1'b0);
        @(negedge clk);
        chk("ready_before_accept", ready, 1'b1);
        chk("line_idle_before_accept", TX_OUT, 1'b1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        chk("start_bit_next_edge", TX_OUT, 1'b0);
        chk("busy_next_edge", busy, 1'b1);
        chk("ready_while_busy", ready, HOLD);
        t0 = cyc;
        wait_low(t1);
        chk($sformatf("busy_cycles_byte%02h", d), t1 - t0, len);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [5:0] presc;
        bit         pen;
        bit         ptype;
        bit         exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1;
        rst           = 1'b1;
        data_valid    = 1'b0;
        P_DATA        = 8'h00;
        prescale      = 6'd8;
        parity_enable = 1'b0;
        parity_type   = 1'b0;

        //          data    presc pen ptype par len
        vecs[0] = '{8'hA5, 6'd8,  0,  0,    0,  80};
        vecs[1] = '{8'h07, 6'd16, 1,  0,    1,  176};
        vecs[2] = '{8'h07, 6'd16, 1,  1,    0,  176};
        vecs[3] = '{8'h00, 6'd1,  0,  0,    0,  10};
        vecs[4] = '{8'h5A, 6'd0,  1,  1,    1,  704};
        vecs[5] = '{8'hFF, 6'd3,  1,  0,    0,  33};
        vecs[6] = '{8'h80, 6'd63, 0,  0,    0,  630};
        vecs[7] = '{8'h81, 6'd2,  1,  1,    1,  22};

        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        mon_abort = 1'b0;

        // Idle after reset
        repeat (100) begin
            @(negedge clk);
            chk("idle_line", TX_OUT, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", ready, 1'b1);
        end

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].data, vecs[i].presc, vecs[i].pen, vecs[i].ptype,
                      vecs[i].exp_par, vecs[i].exp_len);
        end

        // Second strobe during a frame: dropped, or queued back-to-back
        @(posedge clk);
        #1;
        drive(8'h3C, 6'd4, 1'b0, 1'b0);
        push(8'h3C, 6'd4, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        t0 = cyc;
        repeat (19) @(posedge clk);
        #1;
        drive(8'hFF, 6'd4, 1'b0, 1'b0);
        if (HOLD) push(8'hFF, 6'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ready_mid_frame", ready, HOLD);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        wait_low(t1);
        chk("second_strobe_busy_cycles", t1 - t0, HOLD ? 80 : 40);
        repeat (30) @(negedge clk);
        chk("scoreboard_after_second_strobe", sb_q.size(), 0);

`ifdef UART_TX_HOLD_EN
        // Queue a byte, then offer another exactly on the drain edge
        @(posedge clk);
        #1;
        drive(8'hC3, 6'd4, 1'b0, 1'b0);
        push(8'hC3, 6'd4, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        t0 = cyc;
        repeat (9) @(posedge clk);
        #1;
        drive(8'h5E, 6'd4, 1'b0, 1'b0);
        push(8'h5E, 6'd4, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("ready_buffer_full", ready, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        drive(8'hA1, 6'd4, 1'b0, 1'b0);
        push(8'hA1, 6'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ready_on_drain_edge", ready, 1'b1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        wait_low(t1);
        chk("three_frames_busy_cycles", t1 - t0, 120);
        repeat (5) @(negedge clk);
`endif

        // Minimum gap: strobe in the first cycle ready returns
        @(posedge clk);
        #1;
        drive(8'h96, 6'd2, 1'b0, 1'b0);
        push(8'h96, 6'd2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        wait_low(t1);
        chk("ready_after_busy_falls", ready, 1'b1);
        drive(8'h69, 6'd2, 1'b1, 1'b1);
        push(8'h69, 6'd2, 1'b1, (^8'h69) ^ 1'b1, 1'b0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        chk("start_after_one_idle_cycle", TX_OUT, 1'b0);
        t0 = cyc;
        wait_low(t1);
        chk("gap_frame_busy_cycles", t1 - t0, 22);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 (frame cycles 17..20 with P=4)
        @(posedge clk);
        #1;
        drive(8'h3C, 6'd4, 1'b0, 1'b0);
        push(8'h3C, 6'd4, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        repeat (17) @(posedge clk);
        #1;
        rst       = 1'b1;
        mon_abort = 1'b1;
        @(negedge clk);
        chk("line_data_bit3", TX_OUT, 1'b1);
        chk("busy_before_reset", busy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_line", TX_OUT, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", ready, 1'b1);
        sb_q.delete();
        mon_abort = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(8'h81, 6'd5, 1'b1, 1'b0, 1'b0, 55);

        // Reset wins over a simultaneous strobe
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(8'h55, 6'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        chk("reset_priority_line", TX_OUT, 1'b1);
        chk("reset_priority_busy", busy, 1'b0);
        repeat (8) @(negedge clk);
        chk("reset_priority_busy_later", busy, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
